counter_cmd_ctrl: RTL and testbench

Front-end command generator that sits directly upstream of bin_counter and drives its syn_clr, load, en, up and d inputs. It converts four raw, bouncy push-button inputs into clean single-cycle counter commands, with auto-repeat while a count button is held. It also reads back the counter's max_tick/min_tick to support an optional saturating mode.

---
 rtl/counter_cmd_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_counter_cmd_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/counter_cmd_ctrl.sv
// counter_cmd_ctrl: turns four raw push buttons into clean single-cycle
// commands (syn_clr, load, en) plus a direction level (up) for bin_counter.
// Each button is synchronized and debounced. The count buttons auto-repeat
// while held alone.
// Optional feature macro: SATURATE_EN. When it is defined, a step toward an
// end point that the counter has already reached is suppressed.
module counter_cmd_ctrl #(
  parameter int N          = 3,
  parameter int DB_TICKS   = 1000000,
  parameter int RPT_DELAY  = 25000000,
  parameter int RPT_PERIOD = 5000000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         btn_up_i,
  input  logic         btn_dn_i,
  input  logic         btn_clr_i,
  input  logic         btn_load_i,
  input  logic [N-1:0] sw_d,
  input  logic         max_tick,
  input  logic         min_tick,
  output logic         syn_clr,
  output logic         load,
  output logic [N-1:0] d,
  output logic         en,
  output logic         up
);

  localparam int DB_W     = $clog2(DB_TICKS + 1);
  localparam int HOLD_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

  // Bit positions of the buttons in the internal vectors.
  localparam int B_CLR  = 0;
  localparam int B_LOAD = 1;
  localparam int B_UP   = 2;
  localparam int B_DN   = 3;

  typedef enum logic [1:0] {REL, WAIT_PRS, PRS, WAIT_REL} db_state_t;

  logic [3:0] w_raw;
  logic [3:0] r_sync1;
  logic [3:0] r_sync2;
  logic [3:0] w_press;   // one-cycle debounced press events
  logic [3:0] w_level;   // debounced button levels

  assign w_raw = {btn_dn_i, btn_up_i, btn_load_i, btn_clr_i};

  // Two-stage synchronizer for all raw buttons.
  // NOTE: sequential state always uses <= so every stage samples the pre-edge value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_db
    db_state_t       r_state;
    db_state_t       w_state_nxt;
    logic [DB_W-1:0] r_cnt;
    logic [DB_W-1:0] w_cnt_nxt;
    logic            r_press;
    logic            w_press_nxt;

    // Debounce next-state: a level change is accepted after DB_TICKS stable cycles.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_press_nxt = 1'b0;
      case (r_state)
        REL: begin
          if (r_sync2[g]) begin
            w_state_nxt = WAIT_PRS;
            w_cnt_nxt   = DB_W'(1);
          end
        end
        WAIT_PRS: begin
          if (!r_sync2[g]) begin
            w_state_nxt = REL;
            w_cnt_nxt   = '0;
          end else if (r_cnt == DB_W'(DB_TICKS - 1)) begin
            w_state_nxt = PRS;
            w_cnt_nxt   = '0;
            w_press_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + DB_W'(1);
          end
        end
        PRS: begin
          if (!r_sync2[g]) begin
            w_state_nxt = WAIT_REL;
            w_cnt_nxt   = DB_W'(1);
          end
        end
        WAIT_REL: begin
          if (r_sync2[g]) begin
            w_state_nxt = PRS;
            w_cnt_nxt   = '0;
          end else if (r_cnt == DB_W'(DB_TICKS - 1)) begin
            w_state_nxt = REL;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + DB_W'(1);
          end
        end
        default: begin
          w_state_nxt = REL;
          w_cnt_nxt   = '0;
        end
      endcase
    end

    // Debounce state register; the press event is registered with the state.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_state <= REL;
        r_cnt   <= '0;
        r_press <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_press <= w_press_nxt;
      end
    end

    assign w_press[g] = r_press;
    assign w_level[g] = (r_state == PRS) || (r_state == WAIT_REL);
  end

  // Auto-repeat: armed only by a press of one count button while the other is released.
  logic              r_rpt_act;
  logic              r_rpt_phase;   // 0: waiting RPT_DELAY, 1: repeating every RPT_PERIOD
  logic [HOLD_W-1:0] r_hold;
  logic              w_one_held;
  logic              w_rpt_arm;
  logic              w_rpt_tick;

  assign w_one_held = w_level[B_UP] ^ w_level[B_DN];
  assign w_rpt_arm  = (w_press[B_UP] && !w_level[B_DN]) ||
                      (w_press[B_DN] && !w_level[B_UP]);
  assign w_rpt_tick = r_rpt_act && w_one_held &&
                      (r_rpt_phase ? (r_hold == HOLD_W'(RPT_PERIOD))
                                   : (r_hold == HOLD_W'(RPT_DELAY)));

  // Hold timer: counts cycles since the press event, then since the last repeat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rpt_act   <= 1'b0;
      r_rpt_phase <= 1'b0;
      r_hold      <= '0;
    end else if (w_rpt_arm) begin
      r_rpt_act   <= 1'b1;
      r_rpt_phase <= 1'b0;
      r_hold      <= HOLD_W'(1);
    end else if (!w_one_held) begin
      r_rpt_act   <= 1'b0;
      r_rpt_phase <= 1'b0;
      r_hold      <= '0;
    end else if (w_rpt_tick) begin
      r_rpt_phase <= 1'b1;
      r_hold      <= HOLD_W'(1);
    end else if (r_rpt_act) begin
      r_hold <= r_hold + HOLD_W'(1);
    end
  end

  logic w_clr_nxt;
  logic w_load_nxt;
  logic w_step;
  logic w_up_nxt;
  logic w_en_nxt;

  // Command arbitration: clr beats load beats count; lower events are dropped.
  always_comb begin
    w_clr_nxt  = w_press[B_CLR];
    w_load_nxt = !w_press[B_CLR] && w_press[B_LOAD];
    w_step     = 1'b0;
    w_up_nxt   = up;
    if (!w_press[B_CLR] && !w_press[B_LOAD]) begin
      if (w_press[B_UP] && !w_press[B_DN]) begin
        w_up_nxt = 1'b1;
        w_step   = 1'b1;
      end else if (w_press[B_DN] && !w_press[B_UP]) begin
        w_up_nxt = 1'b0;
        w_step   = 1'b1;
      end else if (w_rpt_tick) begin
        w_step = 1'b1;
      end
    end
    w_en_nxt = w_step;
`ifdef SATURATE_EN
    if (w_up_nxt ? max_tick : min_tick) begin
      w_en_nxt = 1'b0;
    end
`endif
  end

`ifndef SATURATE_EN
  // End-point flags only matter when saturation is built in.
  logic w_unused_ticks;
  assign w_unused_ticks = max_tick ^ min_tick;
`endif

  // Registered command outputs; d keeps the last loaded value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      syn_clr <= 1'b0;
      load    <= 1'b0;
      en      <= 1'b0;
      up      <= 1'b1;
      d       <= '0;
    end else begin
      syn_clr <= w_clr_nxt;
      load    <= w_load_nxt;
      en      <= w_en_nxt;
      up      <= w_up_nxt;
      if (w_load_nxt) begin
        d <= sw_d;
      end
    end
  end

endmodule

// File: tb/tb_counter_cmd_ctrl.sv
// Scoreboard bench for counter_cmd_ctrl with N=3, DB_TICKS=4, RPT_DELAY=20,
// RPT_PERIOD=6. Stimulus pushes the expected command (edge index and output
// values) into a queue; a monitor pops and compares whenever a command appears.
// Command latency: raw change driven after edge c -> registered output at edge c+7.
module tb_counter_cmd_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_up_i, btn_dn_i, btn_clr_i, btn_load_i;
  logic [2:0] sw_d;
  logic       max_tick, min_tick;
  logic       syn_clr, load, en, up;
  logic [2:0] d;

  counter_cmd_ctrl #(.N(3), .DB_TICKS(4), .RPT_DELAY(20), .RPT_PERIOD(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_up_i   (btn_up_i),
    .btn_dn_i   (btn_dn_i),
    .btn_clr_i  (btn_clr_i),
    .btn_load_i (btn_load_i),
    .sw_d       (sw_d),
    .max_tick   (max_tick),
    .min_tick   (min_tick),
    .syn_clr    (syn_clr),
    .load       (load),
    .d          (d),
    .en         (en),
    .up         (up)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic       clr;
    logic       ld;
    logic       en;
    logic       up;
    logic [2:0] d;
  } cmd_t;

  cmd_t exp_q[$];
  cmd_t mon_e;
  int   cyc     = 0;
  int   n_check = 0;
  int   n_fail  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_check++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic clr, input logic ld, input logic e,
                      input logic u, input logic [2:0] dv);
    cmd_t x;
    x.cyc = c; x.clr = clr; x.ld = ld; x.en = e; x.up = u; x.d = dv;
    exp_q.push_back(x);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every command the DUT presents must match the head of the queue.
  always @(negedge clk) begin
    if (syn_clr === 1'b1 || load === 1'b1 || en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_check++;
        n_fail++;
        $display("FAIL unexpected_cmd: got clr=%b load=%b en=%b up=%b at edge %0d, required none",
                 syn_clr, load, en, up, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("cmd_edge", cyc,     mon_e.cyc);
        check("syn_clr",  syn_clr, mon_e.clr);
        check("load",     load,    mon_e.ld);
        check("en",       en,      mon_e.en);
        check("up",       up,      mon_e.up);
        check("d",        d,       mon_e.d);
      end
    end
  end

  int c;

  initial begin
    // Test 1: reset with all buttons held
    rst_n = 1'b0;
    {btn_up_i, btn_dn_i, btn_clr_i, btn_load_i} = 4'b1111;
    sw_d = 3'b000; max_tick = 1'b0; min_tick = 1'b0;
    step(2);
    check("rst_syn_clr", syn_clr, 1'b0);
    check("rst_load",    load,    1'b0);
    check("rst_en",      en,      1'b0);
    check("rst_d",       d,       3'b000);
    check("rst_up",      up,      1'b1);
    c = cyc;
    rst_n = 1'b1;
    push(c + 7, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000);  // all pressed: clr wins
    step(10);
    {btn_up_i, btn_dn_i, btn_clr_i, btn_load_i} = 4'b0000;
    step(12);

    // Test 2: bounce on btn_up_i, then stable press
    c = cyc;
    btn_up_i = 1'b1; step(1);
    btn_up_i = 1'b0; step(1);
    btn_up_i = 1'b1; step(1);
    btn_up_i = 1'b0; step(1);
    btn_up_i = 1'b1;
    push(c + 4 + 7, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000);
    step(8);
    btn_up_i = 1'b0;
    step(14);

    // Test 3: load
    sw_d = 3'b011;
    c = cyc;
    btn_load_i = 1'b1;
    push(c + 7, 1'b0, 1'b1, 1'b0, 1'b1, 3'b011);
    step(10);
    btn_load_i = 1'b0;
    step(12);

    // Test 4a: clr and load on the same edge -> clr only
    c = cyc;
    btn_clr_i = 1'b1; btn_load_i = 1'b1;
    push(c + 7, 1'b1, 1'b0, 1'b0, 1'b1, 3'b011);
    step(10);
    btn_clr_i = 1'b0; btn_load_i = 1'b0;
    step(12);

    // Test 5: hold btn_dn_i -> press step, then repeats at +20, +26, +32, +38
    c = cyc;
    btn_dn_i = 1'b1;
    push(c + 7,  1'b0, 1'b0, 1'b1, 1'b0, 3'b011);
    push(c + 27, 1'b0, 1'b0, 1'b1, 1'b0, 3'b011);
    push(c + 33, 1'b0, 1'b0, 1'b1, 1'b0, 3'b011);
    push(c + 39, 1'b0, 1'b0, 1'b1, 1'b0, 3'b011);
    push(c + 45, 1'b0, 1'b0, 1'b1, 1'b0, 3'b011);
    step(41);
    btn_dn_i = 1'b0;
    step(30);

    // Test 4b: up and dn on the same edge -> no en, no repeat, up stays 0
    btn_up_i = 1'b1; btn_dn_i = 1'b1;
    step(30);
    btn_up_i = 1'b0; btn_dn_i = 1'b0;
    step(12);
    check("up_unchanged", up, 1'b0);

    // Test 6: press up with max_tick=1
    max_tick = 1'b1;
    c = cyc;
    btn_up_i = 1'b1;
`ifndef SATURATE_EN
    push(c + 7, 1'b0, 1'b0, 1'b1, 1'b1, 3'b011);
`endif
    step(10);
    btn_up_i = 1'b0;
    step(14);
    check("up_after_sat", up, 1'b1);
    max_tick = 1'b0;

    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
    $finish;
  end

endmodule
